// File: rtl/key_tx_buffer.sv
// Keypad byte FIFO that bursts its contents to a UART transmitter on a send request.
// A small FSM loads each byte, pulses tx_start, waits for the UART handshake, and repeats until the FIFO is empty.
module key_tx_buffer #(
  parameter int DEPTH       = 16,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_valid,
  input  logic                   send,
  input  logic                   busy,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_start,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   sending,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [AW:0]   FULL_COUNT   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE      = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE      = AW'(1);
  localparam logic [TW-1:0] TMR_ONE      = TW'(1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                push, pop;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_start = (state_q == START);
  assign sending  = (state_q != IDLE);

  // A byte arriving while full is still accepted when the same cycle frees a slot.
  assign pop  = (state_q == LOAD) && !empty;
  assign push = wr_valid && (!full || pop);

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE:      if (send && !empty) state_d = LOAD;
      LOAD:      state_d = START;
      START: begin
        state_d = WAIT_ACK;
        tmr_d   = '0;
      end
      WAIT_ACK: begin
        if (busy || tmr_q == TIMEOUT_LAST) state_d = WAIT_DONE;
        else                               tmr_d   = tmr_q + TMR_ONE;
      end
      WAIT_DONE: if (!busy) state_d = empty ? IDLE : LOAD;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    tx_data_d  = pop  ? mem_q[rd_ptr_q]    : tx_data_q;
    overflow_d = overflow_q | (wr_valid & ~push);
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tmr_q      <= tmr_d;
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers and count makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_key_tx_buffer.sv
// Self-checking bench for key_tx_buffer: a vector table for fill/overflow/reset plus
// hand-written bursts; a scoreboard queue holds the bytes expected on each tx_start.
`timescale 1ns/1ps
module tb_key_tx_buffer;

  localparam int DEPTH       = 16;
  localparam int DATA_W      = 8;
  localparam int ACK_TIMEOUT = 15;

  logic              clk      = 1'b0;
  logic              rst      = 1'b1;
  logic              wr_valid = 1'b0;
  logic              send     = 1'b0;
  logic              busy     = 1'b0;
  logic [DATA_W-1:0] wr_data  = '0;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic [4:0]        count;
  logic              full, empty, sending, overflow;

  key_tx_buffer #(
    .DEPTH      (DEPTH),
    .DATA_W     (DATA_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .send    (send),
    .busy    (busy),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .sending (sending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_start = 0;
  int cyc     = 0;
  int last_start_cyc = 0;
  int last_gap  = 0;
  int busy_len  = 10;
  int busy_left = 0;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        wr_valid;
    logic        send;
    logic        accept;
    logic [7:0]  wr_data;
    logic [4:0]  exp_count;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_overflow;
    logic        exp_sending;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic r, input logic wv, input logic s, input logic acc,
                              input logic [7:0] d, input logic [4:0] c, input logic f,
                              input logic e, input logic o, input logic sn);
    vec_t v;
    v.rst = r; v.wr_valid = wv; v.send = s; v.accept = acc; v.wr_data = d;
    v.exp_count = c; v.exp_full = f; v.exp_empty = e; v.exp_overflow = o; v.exp_sending = sn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    exp_q.push_back(b);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_send();
    send = 1'b1;
    step();
    send = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (sending && k < budget) begin
      step();
      k++;
    end
    check("burst_finished_in_budget", sending, 0);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    rst      = v.rst;
    wr_valid = v.wr_valid;
    wr_data  = v.wr_data;
    send     = v.send;
    if (v.accept) exp_q.push_back(v.wr_data);
    step();
    rst = 1'b0; wr_valid = 1'b0; send = 1'b0;
    check($sformatf("vec%0d_count", idx),    count,    v.exp_count);
    check($sformatf("vec%0d_full", idx),     full,     v.exp_full);
    check($sformatf("vec%0d_empty", idx),    empty,    v.exp_empty);
    check($sformatf("vec%0d_overflow", idx), overflow, v.exp_overflow);
    check($sformatf("vec%0d_sending", idx),  sending,  v.exp_sending);
  endtask

  always @(posedge clk) cyc++;

  // UART stand-in: raise busy for busy_len cycles after each tx_start; also scores tx_data.
  always @(negedge clk) begin
    if (tx_start) begin
      n_start++;
      last_gap       = cyc - last_start_cyc;
      last_start_cyc = cyc;
      check("tx_start_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("tx_data_order", tx_data, exp_q.pop_front());
      if (busy_len > 0) begin
        busy      = 1'b1;
        busy_left = busy_len;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;

    vecs[0] = mk(1, 0, 0, 0, 8'h00, 5'd0, 0, 1, 0, 0);
    for (int i = 0; i < 17; i++)
      vecs[i+1] = mk(0, 1, 0, (i < 16), 8'(i), (i < 16) ? 5'(i + 1) : 5'd16,
                     (i >= 15), 0, (i >= 16), 0);
    vecs[18] = mk(1, 1, 1, 0, 8'h55, 5'd0, 0, 1, 0, 0);

    // Reset, fill to full, one dropped byte.
    for (int i = 0; i < 18; i++) apply_vec(vecs[i], i);
    check("reset_tx_start", tx_start, 0);

    // Burst after overflow sends only the 16 stored bytes.
    s0 = n_start;
    pulse_send();
    wait_idle(600);
    check("ovf_burst_starts", n_start - s0, 16);
    check("ovf_burst_queue_drained", exp_q.size(), 0);
    check("ovf_burst_empty", empty, 1);
    check("overflow_sticky", overflow, 1);
    check("tx_data_held_last", tx_data, 8'h0F);

    // Reset dominates wr_valid and send.
    apply_vec(vecs[18], 18);
    exp_q.delete();
    check("reset_tx_data", tx_data, 0);
    check("reset_tx_start2", tx_start, 0);

    // Send on empty is ignored.
    s0 = n_start;
    pulse_send();
    for (int i = 0; i < 5; i++) begin
      check("empty_send_sending", sending, 0);
      step();
    end
    check("empty_send_no_start", n_start - s0, 0);

    // Basic burst with latency check.
    push_byte(8'h31);
    push_byte(8'h32);
    push_byte(8'h33);
    check("basic_count", count, 3);
    s0 = n_start;
    send = 1'b1;
    step();
    send = 1'b0;
    check("latency_n1_tx_start", tx_start, 0);
    check("latency_n1_sending", sending, 1);
    step();
    check("latency_n2_tx_start", tx_start, 1);
    check("latency_n2_tx_data", tx_data, 8'h31);
    wait_idle(200);
    check("basic_starts", n_start - s0, 3);
    check("basic_queue_drained", exp_q.size(), 0);
    check("basic_empty", empty, 1);

    // Wrap-around: push during the first pop on a full FIFO.
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'hA0 + 8'(i));
    check("wrap_full_before", full, 1);
    s0 = n_start;
    send = 1'b1;
    step();
    send = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'hBB;
    exp_q.push_back(8'hBB);
    step();
    wr_valid = 1'b0;
    check("wrap_count_held", count, 16);
    check("wrap_full_held", full, 1);
    check("wrap_no_overflow", overflow, 0);
    wait_idle(600);
    check("wrap_starts", n_start - s0, 17);
    check("wrap_queue_drained", exp_q.size(), 0);

    // Ack timeout: busy never rises.
    do_reset();
    busy_len = 0;
    push_byte(8'h41);
    push_byte(8'h42);
    s0 = n_start;
    pulse_send();
    wait_idle(200);
    check("timeout_starts", n_start - s0, 2);
    check("timeout_start_gap", last_gap, ACK_TIMEOUT + 3);
    check("timeout_queue_drained", exp_q.size(), 0);
    busy_len = 10;

    // Reset mid-burst while in WAIT_DONE.
    do_reset();
    for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i));
    s0 = n_start;
    pulse_send();
    for (int k = 0; k < 50 && n_start == s0; k++) step();
    check("midrst_first_start", n_start - s0, 1);
    step();
    step();
    check("midrst_busy_high", busy, 1);
    check("midrst_count_before", count, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_count", count, 0);
    check("midrst_sending", sending, 0);
    check("midrst_empty", empty, 1);
    s0 = n_start;
    repeat (40) step();
    check("midrst_no_more_starts", n_start - s0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
